div_unit: RTL and testbench
===========================

Name: div_unit

Overview:
- Multi-cycle 32-bit integer divider serving the Ex stage for DIV.W/MOD.W and DIV.WU/MOD.WU.
- Ex drives the operands, signedness, start and cancel. Ex holds its stall request while ready_o is low.
- Returns quotient and remainder together as a 64-bit result.
- Uses radix-2 restoring shift-subtract: one quotient bit per cycle, states FREE/BYZERO/ON/END.

Parameters:
- DATA_W, 32, operand width. Fixed at 32; the iteration counter and result packing assume 32.

Ports:
- clk  input  1  pipeline clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- signed_div_i  input  1  1 = signed (DIV.W/MOD.W), 0 = unsigned.
- opdata1_i  input  32  dividend (Ex reg2_i).
- opdata2_i  input  32  divisor (Ex reg1_i).
- start_i  input  1  request; held high by Ex until ready_o is seen.
- cancel_i  input  1  abort, driven by pipeline flush.
- result_o  output  64  {remainder[63:32], quotient[31:0]}.
- ready_o  output  1  result_o valid.

Behaviour:
- Reset (rst=0, async): state=FREE, ready_o=0, result_o=0, counter=0, internal dividend/divisor registers=0.
- Resetting mid-operation discards all progress; no ready_o follows.
- FREE:
  - start_i=1 & cancel_i=0 & opdata2_i==0 -> BYZERO.
  - start_i=1 & cancel_i=0 & opdata2_i!=0 -> ON.
  - Otherwise stay FREE.
  - On entering ON, latch absolute values. If signed_div_i and op[31]=1, latch two's-complement negation of that op; else latch raw.
  - Latch signed_div_i, opdata1_i[31] and opdata2_i[31] for the final correction.
  - counter=0.
  - ready_o=0 and result_o=0 while in FREE.
- BYZERO:
  - cancel_i=1 -> FREE.
  - Else load quotient=0xFFFFFFFF, remainder=raw opdata1_i, then -> END.
- ON, counter<32:
  - One iteration per cycle.
  - Shift the 64-bit partial {rem, quo} left by 1.
  - If rem >= divisor: rem -= divisor, quo[0]=1; else quo[0]=0.
  - counter+=1.
  - Operand input changes during ON are ignored.
- ON, counter==32, sign correction:
  - Signed and dividend sign != divisor sign -> negate quotient.
  - Signed and dividend negative -> negate remainder.
  - Register result_o, then -> END.
- ON, cancel_i=1 at any counter value -> FREE; no ready_o.
- END:
  - ready_o=1; result_o stable.
  - Stay while start_i=1.
  - start_i=0 -> FREE, with ready_o=0 and result_o=0 the next cycle.
  - cancel_i is ignored in END; Ex already holds the result.
- Latency:
  - Accepting edge k (FREE->ON). ready_o=1 after edge k+33 (32 iterations plus 1 correction).
  - Divide-by-zero: ready_o=1 after edge k+1.
- Arithmetic rules:
  - Quotient truncates toward zero; remainder takes the dividend's sign.
  - 0x80000000 / 0xFFFFFFFF signed yields quotient 0x80000000, remainder 0, with no fault.
- Simultaneous start_i and cancel_i in FREE: cancel wins; stay FREE.
- Back-to-back: a new operation can only begin from FREE. Ex must drop start_i for at least one cycle between divisions.

Test Plan:
- Unsigned 100/7 (signed_div_i=0), start held -> ready_o rises exactly 33 cycles after acceptance; result_o = {0x00000002, 0x0000000E}. Drop start_i -> ready_o=0, result_o=0 next cycle.
- Signed -7/2 (0xFFFFFFF9, 0x00000002) -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF. Then signed 7/-2 -> quotient 0xFFFFFFFD, remainder 0x00000001.
- Signed 0x80000000/0xFFFFFFFF -> {0x00000000, 0x80000000}. Unsigned 0xFFFFFFFF/1 -> {0x0, 0xFFFFFFFF}. Unsigned 0xFFFFFFFF/0xFFFFFFFF -> {0x0, 0x1}.
- Divide-by-zero 0x12345678/0 -> ready_o after 2 edges; result_o = {0x12345678, 0xFFFFFFFF}.
- Cancel: assert cancel_i for one cycle at iteration 10 -> state FREE, ready_o never rises. Restart with 9/3 -> {0x0, 0x3} after 33 cycles.
- Async reset: pull rst low mid-iteration (no clock edge) -> ready_o=0 and result_o=0 immediately. Release and restart 50/5 -> {0x0, 0xA}.

Source files
------------

// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider for DIV.W/MOD.W and DIV.WU/MOD.WU.
// One quotient bit per cycle, then a sign-correction cycle; result is {remainder, quotient}.
module div_unit #(
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  signed_div_i,
  input  logic [DATA_W-1:0]     opdata1_i,
  input  logic [DATA_W-1:0]     opdata2_i,
  input  logic                  start_i,
  input  logic                  cancel_i,
  output logic [2*DATA_W-1:0]   result_o,
  output logic                  ready_o
);

  typedef enum logic [1:0] {
    ST_FREE,
    ST_BYZERO,
    ST_ON,
    ST_END
  } state_t;

  localparam logic [5:0] ITERS = 6'd32;

  state_t state;
  state_t state_nxt;

  logic [5:0]            cnt;
  logic [2*DATA_W-1:0]   part;
  logic [DATA_W-1:0]     dvsr;
  logic                  sgn;
  logic                  neg_dvnd;
  logic                  neg_dvsr;

  logic [DATA_W:0]       rem_sh;
  logic [DATA_W:0]       rem_diff;
  logic                  take;
  logic [2*DATA_W-1:0]   part_nxt;
  logic [DATA_W-1:0]     quo_fix;
  logic [DATA_W-1:0]     rem_fix;

  function automatic logic [DATA_W-1:0] neg_op(input logic [DATA_W-1:0] v);
    return ~v + {{(DATA_W-1){1'b0}}, 1'b1};
  endfunction

  function automatic logic [DATA_W-1:0] abs_op(input logic [DATA_W-1:0] v, input logic s);
    return (s && v[DATA_W-1]) ? neg_op(v) : v;
  endfunction

  // Shift {rem, quo} left and trial-subtract; a clear borrow bit means rem >= divisor.
  always_comb begin
    rem_sh   = {part[2*DATA_W-1:DATA_W], part[DATA_W-1]};
    rem_diff = rem_sh - {1'b0, dvsr};
    take     = ~rem_diff[DATA_W];
    part_nxt = {(take ? rem_diff[DATA_W-1:0] : rem_sh[DATA_W-1:0]),
                part[DATA_W-2:0], take};
  end

  // Quotient sign follows the operand signs; remainder follows the dividend.
  always_comb begin
    quo_fix = part[DATA_W-1:0];
    rem_fix = part[2*DATA_W-1:DATA_W];
    if (sgn && (neg_dvnd != neg_dvsr)) quo_fix = neg_op(part[DATA_W-1:0]);
    if (sgn && neg_dvnd)               rem_fix = neg_op(part[2*DATA_W-1:DATA_W]);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_FREE: begin
        if (start_i && !cancel_i)
          state_nxt = (opdata2_i == '0) ? ST_BYZERO : ST_ON;
      end
      ST_BYZERO: begin
        state_nxt = cancel_i ? ST_FREE : ST_END;
      end
      ST_ON: begin
        if (cancel_i)           state_nxt = ST_FREE;
        else if (cnt == ITERS)  state_nxt = ST_END;
      end
      ST_END: begin
        if (!start_i) state_nxt = ST_FREE;
      end
      default: state_nxt = ST_FREE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_FREE;
      ready_o  <= 1'b0;
      result_o <= '0;
      cnt      <= '0;
      part     <= '0;
      dvsr     <= '0;
      sgn      <= 1'b0;
      neg_dvnd <= 1'b0;
      neg_dvsr <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        ST_FREE: begin
          ready_o  <= 1'b0;
          result_o <= '0;
          if (state_nxt == ST_ON) begin
            part     <= {{DATA_W{1'b0}}, abs_op(opdata1_i, signed_div_i)};
            dvsr     <= abs_op(opdata2_i, signed_div_i);
            sgn      <= signed_div_i;
            neg_dvnd <= opdata1_i[DATA_W-1];
            neg_dvsr <= opdata2_i[DATA_W-1];
            cnt      <= '0;
          end
        end
        ST_BYZERO: begin
          if (!cancel_i) begin
            result_o <= {opdata1_i, {DATA_W{1'b1}}};
            ready_o  <= 1'b1;
          end
        end
        ST_ON: begin
          if (!cancel_i) begin
            if (cnt != ITERS) begin
              part <= part_nxt;
              cnt  <= cnt + 6'd1;
            end else begin
              result_o <= {rem_fix, quo_fix};
              ready_o  <= 1'b1;
            end
          end
        end
        ST_END: begin
          if (!start_i) begin
            ready_o  <= 1'b0;
            result_o <= '0;
          end
        end
        default: begin
          ready_o  <= 1'b0;
          result_o <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: latency, signed/unsigned results, divide-by-zero, cancel, async reset.
module tb_div_unit;

  logic        clk;
  logic        rst;
  logic        signed_div;
  logic [31:0] op1;
  logic [31:0] op2;
  logic        start;
  logic        cancel;
  logic [63:0] result;
  logic        ready;

  int total;
  int passed;

  div_unit #(.DATA_W(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div),
    .opdata1_i    (op1),
    .opdata2_i    (op2),
    .start_i      (start),
    .cancel_i     (cancel),
    .result_o     (result),
    .ready_o      (ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total = total + 1;
    assert (obs === exp) passed = passed + 1;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Issue one division, wait for ready, check latency and result, then release.
  task automatic run_div(input string tag, input logic s, input logic [31:0] a,
                         input logic [31:0] b, input int lat, input logic [63:0] exp);
    int n;
    signed_div = s;
    op1        = a;
    op2        = b;
    start      = 1'b1;
    tick();
    if (lat != 1) begin
      op1 = $urandom;
      op2 = $urandom;
    end
    n = 0;
    while (!ready && n < 60) begin
      tick();
      n++;
    end
    chk({tag, " latency"}, 64'(n), 64'(lat));
    chk({tag, " result"}, result, exp);
    start = 1'b0;
    tick();
    chk({tag, " ready drop"}, {63'b0, ready}, 64'd0);
    chk({tag, " result clear"}, result, 64'd0);
  endtask

  initial begin
    int n;
    logic seen;
    total      = 0;
    passed     = 0;
    rst        = 1'b0;
    signed_div = 1'b0;
    op1        = '0;
    op2        = '0;
    start      = 1'b0;
    cancel     = 1'b0;

    tick();
    tick();
    chk("reset ready", {63'b0, ready}, 64'd0);
    chk("reset result", result, 64'd0);
    rst = 1'b1;
    tick();

    // 100/7 unsigned with hold in END while start stays high
    signed_div = 1'b0;
    op1 = 32'd100;
    op2 = 32'd7;
    start = 1'b1;
    tick();
    op1 = 32'hDEAD_BEEF;
    op2 = 32'h0000_0003;
    n = 0;
    while (!ready && n < 60) begin
      tick();
      n++;
    end
    chk("u100/7 latency", 64'(n), 64'd33);
    chk("u100/7 result", result, {32'h0000_0002, 32'h0000_000E});
    tick();
    tick();
    tick();
    chk("u100/7 hold ready", {63'b0, ready}, 64'd1);
    chk("u100/7 hold result", result, {32'h0000_0002, 32'h0000_000E});
    start = 1'b0;
    tick();
    chk("u100/7 ready drop", {63'b0, ready}, 64'd0);
    chk("u100/7 result clear", result, 64'd0);
    tick();

    run_div("s-7/2", 1'b1, 32'hFFFF_FFF9, 32'h0000_0002, 33, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    run_div("s7/-2", 1'b1, 32'h0000_0007, 32'hFFFF_FFFE, 33, {32'h0000_0001, 32'hFFFF_FFFD});
    run_div("s-100/-7", 1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 33, {32'hFFFF_FFFE, 32'h0000_000E});
    run_div("s min/-1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 33, {32'h0000_0000, 32'h8000_0000});
    run_div("u max/1", 1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 33, {32'h0000_0000, 32'hFFFF_FFFF});
    run_div("u max/max", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, {32'h0000_0000, 32'h0000_0001});
    run_div("u -7 as unsigned/2", 1'b0, 32'hFFFF_FFF9, 32'h0000_0002, 33, {32'h0000_0001, 32'h7FFF_FFFC});
    run_div("div0", 1'b0, 32'h1234_5678, 32'h0000_0000, 1, {32'h1234_5678, 32'hFFFF_FFFF});

    // Cancel at iteration 10: no ready afterwards
    signed_div = 1'b0;
    op1 = 32'd1000;
    op2 = 32'd3;
    start = 1'b1;
    tick();
    for (int i = 0; i < 10; i++) tick();
    cancel = 1'b1;
    start = 1'b0;
    tick();
    cancel = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (ready) seen = 1'b1;
    end
    chk("cancel no ready", {63'b0, seen}, 64'd0);
    chk("cancel result", result, 64'd0);
    run_div("u9/3 after cancel", 1'b0, 32'd9, 32'd3, 33, {32'h0, 32'h3});

    // start and cancel together in FREE: cancel wins until it drops
    signed_div = 1'b0;
    op1 = 32'd21;
    op2 = 32'd4;
    start = 1'b1;
    cancel = 1'b1;
    tick();
    tick();
    cancel = 1'b0;
    run_div("u21/4 after start+cancel", 1'b0, 32'd21, 32'd4, 33, {32'h1, 32'h5});

    // Async reset while holding a result in END
    signed_div = 1'b0;
    op1 = 32'd123;
    op2 = 32'd10;
    start = 1'b1;
    tick();
    n = 0;
    while (!ready && n < 60) begin
      tick();
      n++;
    end
    chk("u123/10 result", result, {32'h3, 32'hC});
    #2;
    rst = 1'b0;
    #1;
    chk("async rst ready", {63'b0, ready}, 64'd0);
    chk("async rst result", result, 64'd0);
    start = 1'b0;
    tick();
    rst = 1'b1;
    tick();

    // Async reset mid-iteration discards the operation
    op1 = 32'd77;
    op2 = 32'd5;
    start = 1'b1;
    tick();
    for (int i = 0; i < 12; i++) tick();
    #2;
    rst = 1'b0;
    #1;
    chk("mid rst ready", {63'b0, ready}, 64'd0);
    chk("mid rst result", result, 64'd0);
    start = 1'b0;
    tick();
    rst = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (ready) seen = 1'b1;
    end
    chk("mid rst no ready", {63'b0, seen}, 64'd0);
    run_div("u50/5 after reset", 1'b0, 32'd50, 32'd5, 33, {32'h0, 32'hA});

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
